valve_sequencer: RTL and testbench
==================================

VALVE_SEQUENCER -- requirements
Module: valve_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000, meaning clk cycles per WAIT time-base tick (1 ms at 100 MHz); legal range 1..2^20.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  program-loaded flag from the UART loader; a rising edge launches a run.
REQ-005 abort  input  1  synchronous stop request, active-high.
REQ-006 read_data  input  13  instruction word from instruction memory, valid one cycle after address changes.
REQ-007 address  output  8  instruction memory read address, registered.
REQ-008 valves  output  8  valve drive lines, registered, 1 = valve open.
REQ-009 busy  output  1  high while a program is running.
REQ-010 done  output  1  high after an END executes, held until the next run starts.
REQ-011 error  output  1  step-limit abort flag, held until the next run starts.

Function
REQ-012 Instruction format SHALL be op = read_data[12:11]:
- 00 SET: valves <= [7:0]; [10:8] ignored.
- 01 WAIT: delay [10:0] ticks.
- 10 JUMP: pc <= [7:0].
- 11 END.
REQ-013 States SHALL be IDLE, FETCH, EXEC, WAIT, DONE; busy = 1 in FETCH/EXEC/WAIT only.
REQ-014 Run start SHALL trigger on a start rising edge detected in IDLE or DONE; it SHALL set pc = 0, clear done and error, and enter FETCH on the next cycle.
REQ-015 start edges in FETCH/EXEC/WAIT SHALL be ignored.
REQ-016 FETCH SHALL last one cycle with address = pc, then go to EXEC; EXEC SHALL sample read_data.
REQ-017 SET SHALL update valves at the end of EXEC, set pc = pc+1, and go to FETCH (2 cycles per SET).
REQ-018 WAIT with N > 0 SHALL load an 11-bit down-counter with N, clear the prescaler, and enter WAIT.
REQ-019 The WAIT state SHALL decrement the counter every TICK_DIV cycles and go to FETCH with pc+1 when it reaches 0; total WAIT-state dwell = N*TICK_DIV cycles.
REQ-020 WAIT with N = 0 SHALL behave as a NOP: pc+1, then FETCH.
REQ-021 JUMP SHALL set pc = target and go to FETCH; a self-jump is legal and loops forever unless REQ-029 applies.
REQ-022 END SHALL go to DONE, set done = 1, and hold valves at their last value.
REQ-023 pc increment SHALL wrap modulo 256 (255 -> 0) with no flag.
REQ-024 abort in any non-IDLE state SHALL force IDLE, valves = 0, and pc = 0 next cycle; abort SHALL take priority over a simultaneous start edge and over instruction execution.
REQ-025 In IDLE, address SHALL equal 0; valves SHALL hold.

Reset
REQ-026 reset SHALL asynchronously force state = IDLE, pc = 0, address = 0, valves = 0, busy = 0, done = 0, error = 0, counters = 0, and the start edge-detector history = 1.
REQ-027 Holding history = 1 SHALL prevent a start level already high at reset release from launching a run.
REQ-028 reset asserted mid-run SHALL close all valves immediately, without waiting for a clock edge.

Configuration
REQ-029 With macro VALVE_STEP_LIMIT_EN defined, a 10-bit executed-instruction counter SHALL be cleared at run start and incremented per EXEC.
REQ-030 Under VALVE_STEP_LIMIT_EN, when the counter reaches 1023 without an END, the block SHALL go to DONE with error = 1, done = 0, and valves = 0.
REQ-031 Without VALVE_STEP_LIMIT_EN, error SHALL be tied 0 and no step counter SHALL exist.

Verification (TICK_DIV = 4)
REQ-032 Program {SET 0xA5, END}, start pulse -> address 0 then 1; valves = 0xA5 three cycles after the start edge; done = 1, busy = 0.
REQ-033 {WAIT 3, SET 0x01, END} -> valves stay 0 for 12 WAIT-state cycles, then become 0x01; WAIT 0 variant -> no dwell.
REQ-034 {SET 0xFF, JUMP 0} with abort pulsed after 50 cycles -> valves = 0x00, busy = 0, state IDLE next cycle.
REQ-035 With VALVE_STEP_LIMIT_EN, {JUMP 0} -> error = 1 after 1023 EXECs, valves = 0; without the macro, it runs until abort.
REQ-036 reset asserted during WAIT with valves = 0x3C -> valves = 0 asynchronously; start held high through reset release -> no run.
REQ-037 SET at address 255 followed by END at address 0 -> pc wraps and the run completes with done = 1.

Source files
------------

// File: rtl/valve_sequencer.sv
`timescale 1ns/1ps
// valve_sequencer: runs a small valve program fetched from an external
// instruction memory (SET / WAIT / JUMP / END), driving eight valve lines.
// Optional build macro VALVE_STEP_LIMIT_EN adds a runaway-program guard that
// stops a run after 1023 executed instructions without an END.
//
// Control protocol: there is no valid/ready pair on this block. start is
// sampled every cycle and a run launches on a 0->1 transition seen while in
// IDLE or DONE; abort is a level acted upon at the next rising edge and wins
// over everything else. read_data must hold the word at address one cycle
// after address changes.
module valve_sequencer #(
    parameter int TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [12:0] read_data,
    output logic [7:0]  address,
    output logic [7:0]  valves,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_WAIT = 2'b01;
    localparam logic [1:0] OP_JUMP = 2'b10;
    localparam logic [1:0] OP_END  = 2'b11;

    // Prescaler counts 0..TICK_DIV-1; keep at least one bit for TICK_DIV = 1.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t        state, state_n;
    logic [7:0]    pc, pc_n;
    logic [7:0]    address_n;
    logic [7:0]    valves_n;
    logic          done_n;
    logic          start_hist;
    logic          start_edge;
    logic [10:0]   wait_cnt, wait_cnt_n;
    logic [PW-1:0] presc, presc_n;
    logic [1:0]    op;

`ifdef VALVE_STEP_LIMIT_EN
    // The 1023rd EXEC is the one that sees 1022 already counted.
    localparam logic [9:0] STEP_LAST = 10'd1022;
    logic [9:0] step_cnt, step_cnt_n;
    logic       error_r, error_n;
    assign error = error_r;
`else
    assign error = 1'b0;
`endif

    assign start_edge = start & ~start_hist;
    assign op         = read_data[12:11];
    assign busy       = (state == S_FETCH) || (state == S_EXEC) || (state == S_WAIT);
    assign state_dbg  = state;

    // Next-state, program counter, valve and timer decisions.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        valves_n   = valves;
        done_n     = done;
        wait_cnt_n = wait_cnt;
        presc_n    = presc;
`ifdef VALVE_STEP_LIMIT_EN
        step_cnt_n = step_cnt;
        error_n    = error_r;
`endif
        if (abort && (state != S_IDLE)) begin
            state_n  = S_IDLE;
            pc_n     = 8'd0;
            valves_n = 8'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // abort also suppresses a launch while already idle
                    if (start_edge && !abort) begin
                        state_n = S_FETCH;
                        pc_n    = 8'd0;
                        done_n  = 1'b0;
`ifdef VALVE_STEP_LIMIT_EN
                        error_n    = 1'b0;
                        step_cnt_n = 10'd0;
`endif
                    end
                end
                S_FETCH: begin
                    state_n = S_EXEC;
                end
                S_EXEC: begin
`ifdef VALVE_STEP_LIMIT_EN
                    step_cnt_n = step_cnt + 10'd1;
                    if ((step_cnt == STEP_LAST) && (op != OP_END)) begin
                        state_n  = S_DONE;
                        error_n  = 1'b1;
                        done_n   = 1'b0;
                        valves_n = 8'd0;
                    end else
`endif
                    begin
                        case (op)
                            OP_SET: begin
                                valves_n = read_data[7:0];
                                pc_n     = pc + 8'd1;
                                state_n  = S_FETCH;
                            end
                            OP_WAIT: begin
                                if (read_data[10:0] != 11'd0) begin
                                    wait_cnt_n = read_data[10:0];
                                    presc_n    = '0;
                                    state_n    = S_WAIT;
                                end else begin
                                    pc_n    = pc + 8'd1;
                                    state_n = S_FETCH;
                                end
                            end
                            OP_JUMP: begin
                                pc_n    = read_data[7:0];
                                state_n = S_FETCH;
                            end
                            default: begin
                                state_n = S_DONE;
                                done_n  = 1'b1;
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (presc == PRESC_MAX) begin
                        presc_n    = '0;
                        wait_cnt_n = wait_cnt - 11'd1;
                        if (wait_cnt == 11'd1) begin
                            pc_n    = pc + 8'd1;
                            state_n = S_FETCH;
                        end
                    end else begin
                        presc_n = presc + PW'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
        // address tracks pc except in IDLE, where it parks at 0
        address_n = (state_n == S_IDLE) ? 8'd0 : pc_n;
    end

    // State and datapath registers; reset closes the valves without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= 8'd0;
            address    <= 8'd0;
            valves     <= 8'd0;
            done       <= 1'b0;
            start_hist <= 1'b1;
            wait_cnt   <= 11'd0;
            presc      <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            address    <= address_n;
            valves     <= valves_n;
            done       <= done_n;
            start_hist <= start;
            wait_cnt   <= wait_cnt_n;
            presc      <= presc_n;
        end
    end

`ifdef VALVE_STEP_LIMIT_EN
    // Executed-instruction counter and step-limit flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt <= 10'd0;
            error_r  <= 1'b0;
        end else begin
            step_cnt <= step_cnt_n;
            error_r  <= error_n;
        end
    end
`endif

endmodule

// File: tb/tb_valve_sequencer.sv
`timescale 1ns/1ps
// tb_valve_sequencer: directed programs against valve_sequencer with
// TICK_DIV = 4. A program-level model expands each program into the
// per-cycle outputs it must produce; a compare process checks them every
// cycle, and literal checks pin the key timing points.
module tb_valve_sequencer;

    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [12:0] read_data;
    logic [7:0]  address;
    logic [7:0]  valves;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  state_dbg;

    valve_sequencer #(.TICK_DIV(TICK)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .read_data (read_data),
        .address   (address),
        .valves    (valves),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .state_dbg (state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // instruction memory: word valid one cycle after address changes
    logic [12:0] mem [256];
    always @(posedge clk) read_data <= mem[address];

    int tests = 0;
    int fails = 0;
    int n_now = 0;
    int sample_no = 0;
    logic [7:0]  m_valves;
    // {addr_chk, address[7:0], valves[7:0], busy, done, error}
    logic [19:0] exp_q[$];
    logic [19:0] cmp_e;

    function automatic logic [12:0] ins_set(input logic [7:0] v);
        return {2'b00, 3'b000, v};
    endfunction
    function automatic logic [12:0] ins_wait(input logic [10:0] n);
        return {2'b01, n};
    endfunction
    function automatic logic [12:0] ins_jump(input logic [7:0] t);
        return {2'b10, 3'b000, t};
    endfunction
    function automatic logic [12:0] ins_end();
        return {2'b11, 11'd0};
    endfunction

    function automatic logic [19:0] rec(input logic chk, input logic [7:0] a,
                                        input logic [7:0] v, input logic b, input logic d);
        return {chk, a, v, b, d, 1'b0};
    endfunction

    // Program-level model: two cycles per instruction (fetch, execute),
    // N*TICK extra cycles for WAIT N, then one DONE sample after END.
    function automatic void expand(input int max_cycles);
        int pc;
        int n;
        int dwell;
        bit ended;
        logic [12:0] ins;
        pc = 0;
        n = 0;
        ended = 1'b0;
        while (n < max_cycles && !ended) begin
            exp_q.push_back(rec(1'b1, pc[7:0], m_valves, 1'b1, 1'b0));
            n++;
            if (n >= max_cycles) break;
            ins = mem[pc];
            exp_q.push_back(rec(1'b1, pc[7:0], m_valves, 1'b1, 1'b0));
            n++;
            case (ins[12:11])
                2'b00: begin
                    m_valves = ins[7:0];
                    pc = (pc + 1) % 256;
                end
                2'b01: begin
                    dwell = int'(ins[10:0]) * TICK;
                    for (int k = 0; k < dwell && n < max_cycles; k++) begin
                        exp_q.push_back(rec(1'b1, pc[7:0], m_valves, 1'b1, 1'b0));
                        n++;
                    end
                    pc = (pc + 1) % 256;
                end
                2'b10: pc = int'(ins[7:0]);
                default: begin
                    if (n < max_cycles) begin
                        exp_q.push_back(rec(1'b0, 8'd0, m_valves, 1'b0, 1'b1));
                        n++;
                    end
                    ended = 1'b1;
                end
            endcase
        end
    endfunction

    // scoreboard: one expected record per cycle while the queue is non-empty
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            tests++;
            if ((cmp_e[19] && (address !== cmp_e[18:11])) || (valves !== cmp_e[10:3]) ||
                (busy !== cmp_e[2]) || (done !== cmp_e[1]) || (error !== cmp_e[0])) begin
                fails++;
                $display("FAIL cycle_check sample %0d: got addr=%h valves=%h busy=%b done=%b error=%b, expected addr=%h(chk=%b) valves=%h busy=%b done=%b error=%b",
                         sample_no, address, valves, busy, done, error,
                         cmp_e[18:11], cmp_e[19], cmp_e[10:3], cmp_e[2], cmp_e[1], cmp_e[0]);
            end
            sample_no++;
        end
    end

    // driver tasks
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        n_now++;
    endtask

    task automatic to_n(input int k);
        while (n_now < k) step();
    endtask

    // Start edge is first seen at the posedge after this negedge (n_now = 0).
    task automatic launch(input int budget);
        @(negedge clk);
        if (budget > 0) expand(budget);
        start = 1'b1;
        n_now = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        m_valves = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 13'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        // reset state; state_dbg reads 0 in IDLE
        check("rst_address", 32'(address), 32'd0);
        check("rst_valves", 32'(valves), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // {SET A5, END}
        mem[0] = ins_set(8'hA5);
        mem[1] = ins_end();
        launch(1000);
        to_n(1);
        start = 1'b0;
        check("set_addr0", 32'(address), 32'd0);
        check("set_busy", 32'(busy), 32'd1);
        to_n(3);
        check("set_valves", 32'(valves), 32'hA5);
        check("set_addr1", 32'(address), 32'd1);
        to_n(5);
        check("set_done", 32'(done), 32'd1);
        check("set_busy_end", 32'(busy), 32'd0);
        drain("set_drain");

        // abort beats a simultaneous start edge in DONE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_vs_start_state", 32'(state_dbg), 32'd0);
        check("abort_vs_start_busy", 32'(busy), 32'd0);
        check("abort_vs_start_valves", 32'(valves), 32'd0);
        start = 1'b0;
        abort = 1'b0;
        m_valves = 8'd0;
        @(negedge clk);

        // {SET FF, JUMP 0} aborted after 50 cycles
        mem[0] = ins_set(8'hFF);
        mem[1] = ins_jump(8'd0);
        launch(50);
        exp_q.push_back(rec(1'b1, 8'd0, 8'd0, 1'b0, 1'b0));
        to_n(1);
        start = 1'b0;
        to_n(50);
        check("loop_valves", 32'(valves), 32'hFF);
        abort = 1'b1;
        to_n(51);
        abort = 1'b0;
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_valves", 32'(valves), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        m_valves = 8'd0;
        drain("abort_drain");

        // {WAIT 3, SET 01, END} with an ignored start edge during WAIT
        mem[0] = ins_wait(11'd3);
        mem[1] = ins_set(8'h01);
        mem[2] = ins_end();
        launch(1000);
        to_n(1);
        start = 1'b0;
        to_n(5);
        start = 1'b1;
        to_n(6);
        start = 1'b0;
        to_n(14);
        check("wait_last_valves", 32'(valves), 32'd0);
        check("wait_last_busy", 32'(busy), 32'd1);
        to_n(17);
        check("wait_after_valves", 32'(valves), 32'h01);
        to_n(19);
        check("wait_done", 32'(done), 32'd1);
        drain("wait_drain");

        // {WAIT 0, SET 02, END}: no dwell
        mem[0] = ins_wait(11'd0);
        mem[1] = ins_set(8'h02);
        mem[2] = ins_end();
        launch(1000);
        to_n(1);
        start = 1'b0;
        to_n(3);
        check("wait0_addr", 32'(address), 32'd1);
        to_n(5);
        check("wait0_valves", 32'(valves), 32'h02);
        drain("wait0_drain");

        // pc wrap: JUMP 255 at 0, SET 5A at 255, END at 0 (loaded mid-run)
        mem[0] = ins_jump(8'd255);
        mem[255] = ins_set(8'h5A);
        launch(0);
        to_n(1);
        start = 1'b0;
        to_n(3);
        mem[0] = ins_end();
        to_n(4);
        check("wrap_addr255", 32'(address), 32'd255);
        to_n(5);
        check("wrap_addr0", 32'(address), 32'd0);
        check("wrap_valves", 32'(valves), 32'h5A);
        to_n(7);
        check("wrap_done", 32'(done), 32'd1);
        check("wrap_busy", 32'(busy), 32'd0);
        m_valves = 8'h5A;

`ifdef VALVE_STEP_LIMIT_EN
        // {SET 33, JUMP 1}: 1023rd EXEC at sample 2045, DONE seen at n = 2047
        mem[0] = ins_set(8'h33);
        mem[1] = ins_jump(8'd1);
        launch(0);
        to_n(1);
        start = 1'b0;
        while (busy && n_now < 3000) step();
        check("limit_cycle", 32'(n_now), 32'd2047);
        check("limit_error", 32'(error), 32'd1);
        check("limit_done", 32'(done), 32'd0);
        check("limit_valves", 32'(valves), 32'd0);
        m_valves = 8'd0;
`else
        // {JUMP 0} keeps running until aborted
        mem[0] = ins_jump(8'd0);
        launch(2100);
        exp_q.push_back(rec(1'b1, 8'd0, 8'd0, 1'b0, 1'b0));
        to_n(1);
        start = 1'b0;
        to_n(2100);
        check("selfjump_busy", 32'(busy), 32'd1);
        check("selfjump_error", 32'(error), 32'd0);
        abort = 1'b1;
        to_n(2101);
        abort = 1'b0;
        m_valves = 8'd0;
        drain("selfjump_drain");
`endif

        // reset during WAIT with valves 3C; start held high through release
        mem[0] = ins_set(8'h3C);
        mem[1] = ins_wait(11'd5);
        mem[2] = ins_end();
        launch(10);
        to_n(1);
        start = 1'b0;
        to_n(10);
        check("prereset_valves", 32'(valves), 32'h3C);
        reset = 1'b1;
        start = 1'b1;
        #1;
        check("async_valves", 32'(valves), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_addr", 32'(address), 32'd0);
        repeat (3) @(negedge clk);
        m_valves = 8'd0;
        for (int i = 0; i < 10; i++) exp_q.push_back(rec(1'b1, 8'd0, 8'd0, 1'b0, 1'b0));
        reset = 1'b0;
        drain("held_start_drain");
        check("held_start_state", 32'(state_dbg), 32'd0);
        start = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
